// File: rtl/mem_responder.sv
// Responder between the datapath's fetch/data requests and a single-port RAM.
// Serves one request at a time (data before fetch), pulses ihit/dhit, and aborts stalled RAM accesses.
module mem_responder #(
   parameter int unsigned TIMEOUT  = 64,
   parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   input  logic        dmemREN,
   input  logic        dmemWEN,
   input  logic [31:0] dmemaddr,
   input  logic [31:0] dmemstore,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        dhit,
   output logic [31:0] dmemload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic        ramready,
   output logic        err,
   output logic [31:0] icount,
   output logic [31:0] dcount
);

   typedef enum logic [1:0] {IDLE, ACCESS, HIT} state_t;
   typedef enum logic [1:0] {IREAD, DREAD, DWRITE} req_t;

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   state_t      state, nextState;
   req_t        reqType, nextReqType;
   logic [31:0] addrReg, nextAddr;
   logic [31:0] storeReg, nextStore;
   logic [7:0]  waitCount, nextWaitCount;
   logic [31:0] nextImemload, nextDmemload;
   logic [31:0] nextIcount, nextDcount;
   logic        nextErr;
   logic        anyReq;
   logic        timedOut;
   logic [31:0] selAddr;

   assign anyReq   = imemREN | dmemREN | dmemWEN;
   assign timedOut = (waitCount == LAST_WAIT) && !ramready;
   assign selAddr  = (dmemREN | dmemWEN) ? dmemaddr : imemaddr;
   assign ramaddr  = addrReg;
   assign ramstore = storeReg;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Strobes and hit pulses come only from the registered state and latched request type.
   always_comb begin
      nextState = state;
      ihit      = 1'b0;
      dhit      = 1'b0;
      ramREN    = 1'b0;
      ramWEN    = 1'b0;
      case (state)
         IDLE: begin
            if (anyReq) begin
               nextState = ACCESS;
            end
         end
         ACCESS: begin
            ramREN = (reqType != DWRITE);
            ramWEN = (reqType == DWRITE);
            if (ramready || timedOut) begin
               nextState = HIT;
            end
         end
         HIT: begin
            ihit      = (reqType == IREAD);
            dhit      = (reqType != IREAD);
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      nextReqType   = reqType;
      nextAddr      = addrReg;
      nextStore     = storeReg;
      nextWaitCount = waitCount;
      nextImemload  = imemload;
      nextDmemload  = dmemload;
      nextIcount    = icount;
      nextDcount    = dcount;
      nextErr       = err;
      case (state)
         IDLE: begin
            if (anyReq) begin
               if (dmemWEN) begin
                  nextReqType = DWRITE;
               end else if (dmemREN) begin
                  nextReqType = DREAD;
               end else begin
                  nextReqType = IREAD;
               end
               nextAddr      = selAddr & 32'hFFFF_FFFC;
               nextStore     = dmemstore;
               nextWaitCount = 8'd0;
            end
         end
         ACCESS: begin
            nextWaitCount = waitCount + 8'd1;
            // A ready RAM beats the watchdog when both land in the same cycle.
            if (ramready) begin
               if (reqType == IREAD) begin
                  nextImemload = ramload;
               end else if (reqType == DREAD) begin
                  nextDmemload = ramload;
               end
            end else if (timedOut) begin
               nextErr = 1'b1;
               if (reqType == IREAD) begin
                  nextImemload = ERR_WORD;
               end else if (reqType == DREAD) begin
                  nextDmemload = ERR_WORD;
               end
            end
         end
         HIT: begin
            if (reqType == IREAD) begin
               nextIcount = icount + 32'd1;
            end else begin
               nextDcount = dcount + 32'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         reqType   <= IREAD;
         addrReg   <= 32'd0;
         storeReg  <= 32'd0;
         waitCount <= 8'd0;
         imemload  <= 32'd0;
         dmemload  <= 32'd0;
         icount    <= 32'd0;
         dcount    <= 32'd0;
         err       <= 1'b0;
      end else begin
         reqType   <= nextReqType;
         addrReg   <= nextAddr;
         storeReg  <= nextStore;
         waitCount <= nextWaitCount;
         imemload  <= nextImemload;
         dmemload  <= nextDmemload;
         icount    <= nextIcount;
         dcount    <= nextDcount;
         err       <= nextErr;
      end
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder end of the datapath/cache request protocol. It accepts the core's instruction-fetch requests (imemREN) and data load/store requests (dmemREN/dmemWEN), arbitrates them onto one single-port RAM handshake, and returns one-cycle ihit/dhit pulses with the returned word.
- Sits between the datapath and the RAM model, in the position a cache occupies in later labs.
- Also provides a RAM timeout watchdog and hit counters for the bench.

Parameters:
- TIMEOUT, 64: maximum ACCESS cycles waiting for ramready before the access is aborted. Range 1..255.
- ERR_WORD, 32'hBAD1BAD1: load value returned on a timed-out read.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous reset, active-high.
- imemREN  in  1  instruction fetch request.
- imemaddr  in  32  fetch byte address.
- dmemREN  in  1  data load request.
- dmemWEN  in  1  data store request.
- dmemaddr  in  32  data byte address.
- dmemstore  in  32  store data.
- ihit  out  1  fetch-complete pulse.
- imemload  out  32  fetched instruction; held between hits.
- dhit  out  1  data-complete pulse, for loads and stores.
- dmemload  out  32  loaded word; held between hits.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM word address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data; valid when ramready=1.
- ramready  in  1  RAM access complete this cycle.
- err  out  1  sticky timeout flag.
- icount  out  32  ihit count, wraps.
- dcount  out  32  dhit count, wraps.

Behaviour:
- Reset: RST=1 acts immediately, including mid-access. It forces state IDLE and drives every output to 0: ihit, dhit, imemload, dmemload, ramREN, ramWEN, ramaddr, ramstore, err, icount, dcount. The RAM strobes drop in the same cycle; no write is completed.
- States: IDLE, ACCESS, HIT.
- IDLE, acceptance:
  - A data request wins: dmemWEN, else dmemREN, takes priority over imemREN.
  - dmemREN and dmemWEN both high is treated as a store.
  - On the accepting edge the block latches: type (I-read, D-read, D-write), the address with bits [1:0] forced to 0, and dmemstore. Timeout counter clears. Next state is ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - ramaddr and ramstore are driven from the latched values.
  - ramREN=1 for reads; ramWEN=1 for the write.
  - Request inputs are ignored in this state.
  - ramready=1: the edge captures ramload into imemload (I-read) or dmemload (D-read); stores leave dmemload unchanged. Next state is HIT.
  - Timeout counter reaching TIMEOUT with ramready=0: the edge loads ERR_WORD into the read target and sets err=1. Next state is HIT.
  - ramready takes precedence over timeout in the same cycle.
- HIT:
  - ihit=1 (I-read) or dhit=1 (D-read or D-write) for exactly this one cycle.
  - The matching counter increments by 1 on the exit edge; 32'hFFFFFFFF wraps to 0.
  - Next state is always IDLE. No acceptance occurs in HIT, because the core changes PC and request lines on this edge.
- Latency: with zero-wait RAM (ramready high in the first ACCESS cycle), the hit arrives 2 cycles after acceptance. In general the hit is asserted 1 cycle after the ramready cycle.
- Withdrawn request: if the request drops while in ACCESS, the access still completes, including committing a write. The hit still pulses, and the counter still counts.
- err: stays set until RST.
- Outputs: ihit, dhit and the RAM strobes are decoded from registered state only; there are no combinational paths from request inputs to outputs.
- Never: ihit and dhit are never high in the same cycle, and ramREN and ramWEN are never high together.

Test Plan:
- Fetch with ramready tied 1: imemREN=1, imemaddr=0x00000040, ramload=0x00A00093. Required: ramREN=1 with ramaddr=0x40 in cycle 1; ihit=1 with imemload=0x00A00093 in cycle 2; icount=1.
- Simultaneous requests: imemREN=1 and dmemWEN=1, dmemaddr=0x102, dmemstore=0xDEADBEEF. Required: the write goes first with ramaddr=0x100 and ramWEN=1; dhit pulses, then IDLE; the fetch is served next and ihit follows 3 cycles after dhit.
- Wait states: dmemREN with ramready held low 5 cycles, then ramload=0x12345678. Required: ramREN stays high 6 cycles; dhit is one cycle with dmemload=0x12345678; dmemload is still held 10 cycles later.
- Timeout with TIMEOUT=4 and ramready never asserted. Required: HIT reached after 4 ACCESS cycles; dmemload=0xBAD1BAD1; err=1 and still 1 after 20 idle cycles.
- Reset mid-write: assert RST in the 2nd ACCESS cycle of a store. Required: ramWEN=0 in the same cycle, all outputs 0, no dhit; after release a new fetch completes normally.
- Counter wrap: preload via 2^32-1 is impractical, so force dcount=0xFFFFFFFF in the bench, then one store. Required: dcount=0.
